// File: rtl/instruction_fetch.sv
// PC and fetch sequencing for a MIPS-style front end: sequential fetch, branch
// delay slot, stall hold, halt on fetch from address 0 and misaligned-target fault.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    output logic [31:0]            instr_address,
    output logic [31:0]            link_address,
    output logic                   delay_slot,
    output logic                   active,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pending_valid;
    logic [31:0] pending_target;
    logic        adv;

    assign adv      = active & ~stall;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_VECTOR;
            pending_valid  <= 1'b0;
            pending_target <= 32'd0;
            active         <= 1'b1;
            fault          <= 1'b0;
            fetch_count    <= '0;
        end else if (adv) begin
            fetch_count <= fetch_count + 1'b1;
            if (pending_valid) begin
                // A redirect presented during the delay slot is dropped here.
                pending_valid <= 1'b0;
                if (pending_target[1:0] == 2'b00) begin
                    pc <= pending_target;
                    if (pending_target == 32'd0) begin
                        active <= 1'b0;
                    end
                end else begin
                    fault  <= 1'b1;
                    active <= 1'b0;
                end
            end else begin
                pc <= pc_plus4;
                if (pc_plus4 == 32'd0) begin
                    // Wrapping into address 0 halts; no redirect is left pending.
                    active <= 1'b0;
                end else if (redirect_valid) begin
                    pending_valid  <= 1'b1;
                    pending_target <= redirect_target;
                end
            end
        end
    end

    assign instr_address = pc;
    assign link_address  = pc + 32'd8;
    assign delay_slot    = pending_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, delay slot,
// stalls, halt, PC wrap, misaligned fault and reset in the delay slot.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_address;
    logic [31:0] link_address;
    logic        delay_slot;
    logic        active;
    logic        fault;
    logic [31:0] fetch_count;

    int vectors = 0;
    int errors  = 0;

    instruction_fetch #(
        .RESET_VECTOR(32'hBFC00000),
        .COUNT_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_address  (instr_address),
        .link_address   (link_address),
        .delay_slot     (delay_slot),
        .active         (active),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] addr, input logic ds,
                               input logic act, input logic flt, input logic [31:0] cnt);
        check({tag, ".addr"},   instr_address,      addr);
        check({tag, ".ds"},     {31'd0, delay_slot}, {31'd0, ds});
        check({tag, ".active"}, {31'd0, active},     {31'd0, act});
        check({tag, ".fault"},  {31'd0, fault},      {31'd0, flt});
        check({tag, ".count"},  fetch_count,         cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;

        // Reset state and sequential fetch
        do_reset();
        check_state("rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0, 32'd0);
        check("rst.link", link_address, 32'hBFC00008);
        step(); check("seq1.addr", instr_address, 32'hBFC00004);
        step(); check("seq2.addr", instr_address, 32'hBFC00008);
        step(); check_state("seq3", 32'hBFC0000C, 1'b0, 1'b1, 1'b0, 32'd3);
        check("seq3.link", link_address, 32'hBFC00014);

        // Branch with delay slot
        do_reset(); run(2);
        check("br.pre", instr_address, 32'hBFC00008);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        step(); check_state("br.ds", 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 32'd3);
        redirect_valid = 1'b0;
        step(); check_state("br.tgt", 32'hBFC00100, 1'b0, 1'b1, 1'b0, 32'd4);
        check("br.link", link_address, 32'hBFC00108);

        // Stalls across a redirect
        do_reset(); run(2);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100; stall = 1'b1;
        step(); check_state("st.s1", 32'hBFC00008, 1'b0, 1'b1, 1'b0, 32'd2);
        step(); check_state("st.s2", 32'hBFC00008, 1'b0, 1'b1, 1'b0, 32'd2);
        stall = 1'b0;
        step(); check_state("st.ds", 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 32'd3);
        redirect_valid = 1'b0; stall = 1'b1;
        step(); check_state("st.dss", 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 32'd3);
        stall = 1'b0;
        step(); check_state("st.tgt", 32'hBFC00100, 1'b0, 1'b1, 1'b0, 32'd4);

        // Halt on jump to 0
        do_reset(); run(4);
        check("halt.pre", instr_address, 32'hBFC00010);
        redirect_valid = 1'b1; redirect_target = 32'h00000000;
        step(); check_state("halt.ds", 32'hBFC00014, 1'b1, 1'b1, 1'b0, 32'd5);
        redirect_valid = 1'b0;
        step(); check_state("halt.0", 32'h00000000, 1'b0, 1'b0, 1'b0, 32'd6);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        run(5); check_state("halt.hold", 32'h00000000, 1'b0, 1'b0, 1'b0, 32'd6);
        redirect_valid = 1'b0;

        // Sequential wrap from FFFFFFFC halts
        do_reset(); run(2);
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        step(); redirect_valid = 1'b0;
        step(); check_state("wrap.top", 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'd4);
        check("wrap.link", link_address, 32'h00000004);
        step(); check_state("wrap.0", 32'h00000000, 1'b0, 1'b0, 1'b0, 32'd5);
        step(); check_state("wrap.hold", 32'h00000000, 1'b0, 1'b0, 1'b0, 32'd5);

        // Misaligned target
        do_reset(); run(2);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00102;
        step(); check_state("mis.ds", 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 32'd3);
        redirect_valid = 1'b0;
        step(); check_state("mis.flt", 32'hBFC0000C, 1'b0, 1'b0, 1'b1, 32'd4);
        step(); check_state("mis.hold", 32'hBFC0000C, 1'b0, 1'b0, 1'b1, 32'd4);
        do_reset(); check_state("mis.rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0, 32'd0);
        step(); check("mis.run", instr_address, 32'hBFC00004);

        // Branch in delay slot ignored, then reset while in a delay slot
        do_reset(); run(2);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        step(); check_state("bds.ds", 32'hBFC0000C, 1'b1, 1'b1, 1'b0, 32'd3);
        redirect_target = 32'hBFC00200;
        step(); check_state("bds.tgt", 32'hBFC00100, 1'b0, 1'b1, 1'b0, 32'd4);
        redirect_valid = 1'b0;
        step(); check_state("bds.seq", 32'hBFC00104, 1'b0, 1'b1, 1'b0, 32'd5);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00300;
        step(); check_state("rds.ds", 32'hBFC00108, 1'b1, 1'b1, 1'b0, 32'd6);
        reset = 1'b1; stall = 1'b1;
        step(); check_state("rds.rst", 32'hBFC00000, 1'b0, 1'b1, 1'b0, 32'd0);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        step(); check_state("rds.run", 32'hBFC00004, 1'b0, 1'b1, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. It owns the PC and drives the word address on `instr_address`. It implements MIPS branch-delay-slot sequencing for redirects from the decode/branch logic, holds on stalls, and detects the halt condition (fetch from address 0). It also flags misaligned redirect targets.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000, PC value loaded on reset.
- `COUNT_WIDTH`, 32, width of the fetch counter.

Ports:
- `clk`, in, 1, system clock; all state updates on rising edge.
- `reset`, in, 1. Reset is synchronous and active-high. It is sampled on the rising edge of `clk` and overrides all other inputs.
- `stall`, in, 1, hold the current fetch; all inputs except `reset` are ignored while high.
- `redirect_valid`, in, 1, the instruction at the current PC is a taken branch/jump.
- `redirect_target`, in, 32, byte address of the branch/jump destination.
- `instr_address`, out, 32, registered PC presented to instruction memory.
- `link_address`, out, 32, `instr_address + 8` (combinational), for JAL/JALR/BxxAL.
- `delay_slot`, out, 1, registered; high while the current fetch is a delay slot with a pending redirect.
- `active`, out, 1, registered; high while the CPU is executing.
- `fault`, out, 1, registered; sticky misaligned-target flag.
- `fetch_count`, out, `COUNT_WIDTH`, registered number of accepted PC advances since reset.

## Operation
- **State:** `pc`, `pending_valid`, `pending_target`, `active`, `fault`, `fetch_count`.
- **Advance condition:** `adv = active & ~stall & ~reset`. When `adv` is low, all state holds.
- **Sequential advance** (`pending_valid=0`, `redirect_valid=0`):
  - `pc <= pc + 4`.
  - Arithmetic is modulo 2^32, so the PC wraps 32'hFFFFFFFC -> 0, which halts.
- **Redirect accept** (`pending_valid=0`, `redirect_valid=1`):
  - `pc <= pc + 4` to fetch the delay slot.
  - `pending_valid <= 1`, `pending_target <= redirect_target`.
- **Pending resolve** (`pending_valid=1`):
  - If `pending_target[1:0] == 0`: `pc <= pending_target` and `pending_valid <= 0`.
  - Otherwise: `pc` holds at the delay-slot address, `fault <= 1`, `active <= 0`, `pending_valid <= 0`.
  - A `redirect_valid` asserted during the delay slot (branch in delay slot) is ignored. No error is raised.
- **Halt:** any advance whose next-PC value is 32'h00000000 loads `pc <= 0` and `active <= 0` on the same edge. After that, `instr_address` stays at 0 until reset.
- **Counting:** `fetch_count <= fetch_count + 1` on every `adv` edge. This includes the edge that halts and the edge that faults. The counter wraps at 2^COUNT_WIDTH.
- **Output mapping:**
  - `delay_slot` = `pending_valid`.
  - `instr_address` = `pc`.
- **Reset values:**
  - `instr_address` = `RESET_VECTOR`.
  - `link_address` = `RESET_VECTOR + 8`.
  - `delay_slot` = 0, `active` = 1, `fault` = 0, `fetch_count` = 0.
  - Pending state is cleared.
- **Reset mid-operation:** reset discards any pending redirect, stall, halt or fault state in the same edge.

## Timing
- **Address latency:** the memory is read combinationally, so the instruction for `instr_address` is valid in the same cycle. Branch logic drives `redirect_valid`/`redirect_target` combinationally from that instruction in that cycle.
- **Redirect latency:** redirect accepted at edge N -> delay slot at `instr_address` after N -> target at `instr_address` after edge N+1 (absent stalls).
- **Stalls:** a stall in any cycle extends that cycle only; no input is sampled.
  - `redirect_valid` must remain asserted across a stall while the same branch is presented.
  - A stall during the delay slot keeps `pending_valid` set.
- **Simultaneous events:**
  - `reset` beats `stall` and `redirect_valid`.
  - `stall` beats `redirect_valid`.
  - Pending resolve beats a new redirect.
- **Halt/fault timing:** `active` and `fault` change on the same edge that loads the final `pc`. There are no outputs after halt other than held values.

## Test plan
- **Reset and sequential fetch:** assert `reset` for 1 cycle, then run 3 cycles -> `instr_address` = BFC00000, BFC00004, BFC00008, BFC0000C; `fetch_count` = 3; `active` = 1; `link_address` = BFC00014 in the last cycle.
- **Branch with delay slot:** `redirect_valid=1`, target BFC00100, at PC BFC00008 -> next BFC0000C with `delay_slot=1`, then BFC00100 with `delay_slot=0`.
- **Stalls across a redirect:** `stall=1` for 2 cycles at PC BFC00008 with redirect held, then a stall of 1 cycle in the delay slot -> PC sequence BFC00008 ×3, BFC0000C ×2, BFC00100; `fetch_count` increments only 2 times.
- **Halt on jump to 0:** redirect target 0 at BFC00010 -> BFC00014, then 0 with `active=0`. PC stays 0 for 5 further cycles and `fetch_count` is frozen.
- **Misaligned target:** redirect target BFC00102 -> PC holds at delay slot BFC0000C, `fault=1`, `active=0`. Asserting `reset` then clears `fault` and restarts at BFC00000.
- **Branch in delay slot and reset mid-delay-slot:**
  - A second redirect in the delay slot (target BFC00200) is ignored and the PC goes to the first target.
  - Reset asserted while `delay_slot=1` -> BFC00000 with `delay_slot=0`.
